alu_mult_ctrl: RTL and testbench

Multi-cycle sequencer that computes a 32x32 -> 64-bit product (HI/LO, as for MIPS MULTU) by driving a shared `alu` instance through repeated additions, one bit per cycle. It issues ALU operands and selectors, captures R and flagC, and exposes a start/busy/done handshake to the core control unit. The ALU itself stays outside this block and is wired to the alu* ports.

---
 rtl/alu_mult_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_mult_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_ctrl.sv
// rtl/alu_mult_ctrl.sv - shift-add 32x32->64 multiply sequencer driving an external ALU, one bit per cycle.
// Optional signed operation (isSigned port, sign fix-up) is built when SIGNED_MULT_EN is defined.
module alu_mult_ctrl #(
    parameter int BUS_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BUS_SIZE-1:0] opA,
    input  logic [BUS_SIZE-1:0] opB,
`ifdef SIGNED_MULT_EN
    input  logic                isSigned,
`endif
    output logic                busy,
    output logic                done,
    output logic [BUS_SIZE-1:0] resHi,
    output logic [BUS_SIZE-1:0] resLo,
    output logic [BUS_SIZE-1:0] aluA,
    output logic [BUS_SIZE-1:0] aluB,
    output logic [3:0]          aluSel,
    output logic                aluCarryIn,
    input  logic [BUS_SIZE-1:0] aluR,
    input  logic                aluFlagC
);

    localparam int CW = $clog2(BUS_SIZE);
    localparam logic [CW-1:0] LAST_COUNT = CW'(BUS_SIZE - 1);
    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_ZERO = 4'b0101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType              state;
    logic [BUS_SIZE-1:0]   mcand;
    logic [BUS_SIZE-1:0]   hi;
    logic [BUS_SIZE-1:0]   lo;
    logic [CW-1:0]         count;
    logic [BUS_SIZE-1:0]   nextHi;
    logic [BUS_SIZE-1:0]   nextLo;
    logic [BUS_SIZE-1:0]   loadA;
    logic [BUS_SIZE-1:0]   loadB;
    logic [2*BUS_SIZE-1:0] product;
`ifdef SIGNED_MULT_EN
    logic                  sign;
`endif

    // One shift-add step: the carry-out becomes the new MSB of hi, the add's LSB shifts into lo.
    always_comb begin
        nextHi = {aluFlagC, aluR[BUS_SIZE-1:1]};
        nextLo = {aluR[0], lo[BUS_SIZE-1:1]};
    end

    // Operands are loaded as magnitudes; the sign is restored on the final product.
    always_comb begin
        loadA   = opA;
        loadB   = opB;
        product = {nextHi, nextLo};
`ifdef SIGNED_MULT_EN
        if (isSigned && opA[BUS_SIZE-1]) loadA = -opA;
        if (isSigned && opB[BUS_SIZE-1]) loadB = -opB;
        if (sign) product = -{nextHi, nextLo};
`endif
    end

    always_comb begin
        aluSel     = SEL_ZERO;
        aluA       = '0;
        aluB       = '0;
        aluCarryIn = 1'b0;
        if (state == RUN) begin
            aluSel = SEL_ADD;
            aluA   = hi;
            aluB   = lo[0] ? mcand : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            resHi <= '0;
            resLo <= '0;
`ifdef SIGNED_MULT_EN
            sign  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= loadA;
                        lo    <= loadB;
                        hi    <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SIGNED_MULT_EN
                        sign  <= isSigned & (opA[BUS_SIZE-1] ^ opB[BUS_SIZE-1]);
`endif
                    end
                end
                RUN: begin
                    hi    <= nextHi;
                    lo    <= nextLo;
                    count <= count + 1'b1;
                    // Results come from the step being completed on this edge, so they are valid with done.
                    if (count == LAST_COUNT) begin
                        state <= DONE;
                        done  <= 1'b1;
                        resHi <= product[2*BUS_SIZE-1:BUS_SIZE];
                        resLo <= product[BUS_SIZE-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// tb/tb_alu_mult_ctrl.sv - self-checking bench for alu_mult_ctrl with a behavioural ALU and product model.
module tb_alu_mult_ctrl;

    localparam int W = 32;
`ifdef SIGNED_MULT_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
`ifdef SIGNED_MULT_EN
    logic         isSignedDrv;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] resHi;
    logic [W-1:0] resLo;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [3:0]   aluSel;
    logic         aluCarryIn;
    logic [W-1:0] aluR;
    logic         aluFlagC;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    alu_mult_ctrl #(.BUS_SIZE(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opA        (opA),
        .opB        (opB),
`ifdef SIGNED_MULT_EN
        .isSigned   (isSignedDrv),
`endif
        .busy       (busy),
        .done       (done),
        .resHi      (resHi),
        .resLo      (resLo),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluSel     (aluSel),
        .aluCarryIn (aluCarryIn),
        .aluR       (aluR),
        .aluFlagC   (aluFlagC)
    );

    // Behavioural ALU: add with unsigned carry-out, or R=0.
    always_comb begin
        {aluFlagC, aluR} = '0;
        if (aluSel == 4'b0000)
            {aluFlagC, aluR} = {1'b0, aluA} + {1'b0, aluB} + {{W{1'b0}}, aluCarryIn};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = $signed({{32{a[W-1]}}, a});
            sb = $signed({{32{b[W-1]}}, b});
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // injKind: 0 none, 1 extra start with 9x9 at cycle injCycle, 2 reset at cycle injCycle.
    task automatic doMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input int injCycle, input int injKind, input string tag);
        logic [63:0] expP;
        logic [63:0] res;
        int doneAt;
        int doneCnt;
        int busyCnt;
        int selErr;
        expP = refProd(a, b, sgn);
        @(negedge clk);
        opA = a;
        opB = b;
`ifdef SIGNED_MULT_EN
        isSignedDrv = sgn;
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        doneAt = -1; doneCnt = 0; busyCnt = 0; selErr = 0; res = '0;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 2) begin
                opA = $urandom;
                opB = $urandom;
`ifdef SIGNED_MULT_EN
                isSignedDrv = 1'($urandom);
`endif
            end
            if (injKind == 2 && n == injCycle) begin
                reset = 1'b1;
                #1;
                check({tag, " rst busy"}, 64'(busy), 64'd0);
                check({tag, " rst done"}, 64'(done), 64'd0);
                check({tag, " rst res"}, {resHi, resLo}, 64'd0);
                check({tag, " rst aluSel"}, 64'(aluSel), 64'h5);
                check({tag, " rst nodone"}, 64'(doneCnt), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (injKind == 1 && n == injCycle) begin
                opA = 9; opB = 9; start = 1'b1;
            end
            if (injKind == 1 && n == injCycle + 1) start = 1'b0;
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt = n;
                    res = {resHi, resLo};
                end
            end
            if (aluSel !== ((busy && !done) ? 4'b0000 : 4'b0101)) selErr++;
            if (aluCarryIn !== 1'b0) selErr++;
        end
        check({tag, " done cycle"}, 64'(doneAt), 64'd33);
        check({tag, " done pulses"}, 64'(doneCnt), 64'd1);
        check({tag, " busy cycles"}, 64'(busyCnt), 64'd33);
        check({tag, " product"}, res, expP);
        check({tag, " held"}, {resHi, resLo}, expP);
        check({tag, " alu ctl"}, 64'(selErr), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opA = '0;
        opB = '0;
`ifdef SIGNED_MULT_EN
        isSignedDrv = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset res", {resHi, resLo}, 64'd0);
        check("reset aluSel", 64'(aluSel), 64'h5);
        check("reset aluA", 64'(aluA), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        doMul(32'd3, 32'd5, 1'b0, 0, 0, "3x5");
        check("3x5 const", {resHi, resLo}, 64'h0000_0000_0000_000F);
        doMul(32'd100, 32'hFFFF_FFFB, 1'b0, 0, 0, "100xFFFB");
        check("100xFFFB const", {resHi, resLo}, 64'h0000_0063_FFFF_FE0C);
        doMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, "maxsq");
        check("maxsq const", {resHi, resLo}, 64'hFFFF_FFFE_0000_0001);
        doMul(32'd0, 32'h1234_5678, 1'b0, 0, 0, "zero");
        doMul(32'd7, 32'd6, 1'b0, 10, 1, "ignstart");
        check("ignstart const", {resHi, resLo}, 64'd42);
        doMul(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 20, 2, "abort");
        doMul(32'd11, 32'd13, 1'b0, 0, 0, "postrst");

        if (HAS_SIGNED) begin
            doMul(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, "s -3x5");
            check("s -3x5 const", {resHi, resLo}, 64'hFFFF_FFFF_FFFF_FFF1);
            doMul(32'hFFFF_FFFD, 32'd5, 1'b0, 0, 0, "u -3x5");
            check("u -3x5 const", {resHi, resLo}, 64'h0000_0004_FFFF_FFF1);
            doMul(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, "s minsq");
            doMul(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, "s minxm1");
        end

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic rs;
            ra = $urandom;
            rb = $urandom;
            rs = HAS_SIGNED ? 1'($urandom) : 1'b0;
            doMul(ra, rb, rs, 0, 0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
